// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read port between the A and B operand
// address FIFOs, with in-order response steering and per-destination credits.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 256,
    parameter int DATA_FIFO_DEPTH = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic                  a_empty_i,
    output logic                  a_pop_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic                  b_empty_i,
    output logic                  b_pop_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] a_data_o,
    output logic                  a_data_wr_o,
    input  logic                  a_data_rd_i,
    output logic [DATA_WIDTH-1:0] b_data_o,
    output logic                  b_data_wr_o,
    input  logic                  b_data_rd_i,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int CW = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DATA_FIFO_DEPTH);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          state;
    logic            last_grant;
    logic [CW-1:0]   a_credit;
    logic [CW-1:0]   b_credit;
    logic [OW-1:0]   outstanding;
    logic            tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]   tag_wr_ptr;
    logic [PW-1:0]   tag_rd_ptr;
    logic [OW-1:0]   tag_count;

    logic rsp_pop;
    logic rsp_err;
    logic rsp_tag;
    logic slot_free;
    logic can_select;
    logic a_elig;
    logic b_elig;
    logic pick_a;
    logic pick_b;
    logic select;
    logic a_rd_ok;
    logic b_rd_ok;
    logic a_rd_err;
    logic b_rd_err;

    // A returning read frees its slot in the same cycle, so a full window can
    // still issue when rvalid arrives.
    always_comb begin
        rsp_pop    = mem_rvalid_i && (tag_count != '0);
        rsp_err    = mem_rvalid_i && (tag_count == '0);
        rsp_tag    = tag_mem[tag_rd_ptr];
        slot_free  = (outstanding < OUT_MAX) || rsp_pop;
        can_select = (state == IDLE) || mem_gnt_i;
        a_elig     = !a_empty_i && (a_credit != '0) && slot_free && can_select;
        b_elig     = !b_empty_i && (b_credit != '0) && slot_free && can_select;
        pick_a     = a_elig && (!b_elig || last_grant);
        pick_b     = b_elig && !pick_a;
        select     = pick_a || pick_b;
        a_rd_ok    = a_data_rd_i && (a_credit != CREDIT_MAX);
        b_rd_ok    = b_data_rd_i && (b_credit != CREDIT_MAX);
        a_rd_err   = a_data_rd_i && (a_credit == CREDIT_MAX);
        b_rd_err   = b_data_rd_i && (b_credit == CREDIT_MAX);
    end

    assign a_pop_o = pick_a;
    assign b_pop_o = pick_b;
    assign idle_o  = (state == IDLE) && (outstanding == '0) && (tag_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (select) begin
                        state      <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pick_a ? a_addr_i : b_addr_i;
                        last_grant <= pick_b;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        if (select) begin
                            mem_addr_o <= pick_a ? a_addr_i : b_addr_i;
                            last_grant <= pick_b;
                        end else begin
                            state     <= IDLE;
                            mem_req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Credits and the outstanding window; a simultaneous take and return cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_credit    <= CREDIT_MAX;
            b_credit    <= CREDIT_MAX;
            outstanding <= '0;
            err_o       <= 1'b0;
        end else begin
            case ({pick_a, a_rd_ok})
                2'b10:   a_credit <= a_credit - 1'b1;
                2'b01:   a_credit <= a_credit + 1'b1;
                default: a_credit <= a_credit;
            endcase
            case ({pick_b, b_rd_ok})
                2'b10:   b_credit <= b_credit - 1'b1;
                2'b01:   b_credit <= b_credit + 1'b1;
                default: b_credit <= b_credit;
            endcase
            case ({select, rsp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (rsp_err || a_rd_err || b_rd_err) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (select) begin
                tag_wr_ptr <= (tag_wr_ptr == PTR_LAST) ? '0 : tag_wr_ptr + 1'b1;
            end
            if (rsp_pop) begin
                tag_rd_ptr <= (tag_rd_ptr == PTR_LAST) ? '0 : tag_rd_ptr + 1'b1;
            end
            case ({select, rsp_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // Tag storage needs no reset; entries are only read when tag_count says valid.
    always_ff @(posedge clk) begin
        if (select) begin
            tag_mem[tag_wr_ptr] <= pick_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_data_o    <= '0;
            b_data_o    <= '0;
            a_data_wr_o <= 1'b0;
            b_data_wr_o <= 1'b0;
        end else begin
            a_data_wr_o <= rsp_pop && !rsp_tag;
            b_data_wr_o <= rsp_pop && rsp_tag;
            if (rsp_pop && !rsp_tag) begin
                a_data_o <= mem_rdata_i;
            end
            if (rsp_pop && rsp_tag) begin
                b_data_o <= mem_rdata_i;
            end
        end
    end

endmodule
